am_prototype_trainer: RTL



---
 rtl/am_prototype_trainer.sv | 109 ++++++++++
 1 files changed

// File: rtl/am_prototype_trainer.sv
// Training-side writer for the associative memory: bundles a batch of labelled
// hypervectors into one majority-vote class prototype plus its label and beat count.
module am_prototype_trainer #(
  parameter int HV_DIMENSION = 2000,
  parameter int LABEL_WIDTH  = 1,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                   Clk_CI,
  input  logic                   Reset_RBI,
  input  logic                   ValidIn_SI,
  output logic                   ReadyOut_SO,
  input  logic [0:HV_DIMENSION-1] HypervectorIn_DI,
  input  logic [LABEL_WIDTH-1:0] LabelIn_DI,
  input  logic                   LastIn_SI,
  output logic                   ValidOut_SO,
  input  logic                   ReadyIn_SI,
  output logic [0:HV_DIMENSION-1] PrototypeOut_DO,
  output logic [LABEL_WIDTH-1:0] LabelOut_DO,
  output logic [CNT_WIDTH-1:0]   CountOut_DO
);

  localparam logic [1:0] IDLE          = 2'd0;
  localparam logic [1:0] ACCUM         = 2'd1;
  localparam logic [1:0] FINAL         = 2'd2;
  localparam logic [1:0] OUTPUT_STABLE = 2'd3;

  localparam logic [CNT_WIDTH-1:0] MAX_CNT = {CNT_WIDTH{1'b1}};

  logic [1:0]             state_SP, state_SN;
  logic [CNT_WIDTH-1:0]   bitCnt_DP [HV_DIMENSION];
  logic [CNT_WIDTH-1:0]   sampleCnt_DP, sampleCntNext_D;
  logic [0:HV_DIMENSION-1] tieBreak_DP;
  logic [LABEL_WIDTH-1:0] label_DP;
  logic                   beat_S, firstBeat_S, closing_S;

  // Compared one bit wider than the counters so 2*cnt never wraps.
  function automatic logic majorityBit(input logic [CNT_WIDTH-1:0] ones,
                                       input logic [CNT_WIDTH-1:0] total,
                                       input logic                 tie);
    logic [CNT_WIDTH:0] twice;
    logic [CNT_WIDTH:0] n;
    twice = {ones, 1'b0};
    n     = {1'b0, total};
    if (twice > n)      return 1'b1;
    else if (twice < n) return 1'b0;
    else                return tie;
  endfunction

  assign ReadyOut_SO     = (state_SP == IDLE) || (state_SP == ACCUM);
  assign ValidOut_SO     = (state_SP == OUTPUT_STABLE);
  assign beat_S          = ValidIn_SI && ReadyOut_SO;
  assign firstBeat_S     = (state_SP == IDLE);
  assign sampleCntNext_D = firstBeat_S ? CNT_WIDTH'(1) : sampleCnt_DP + CNT_WIDTH'(1);
  // A full sample counter forces the batch closed before any counter can overflow.
  assign closing_S       = LastIn_SI || (sampleCntNext_D == MAX_CNT);

  always_comb begin
    state_SN = state_SP;
    case (state_SP)
      IDLE, ACCUM:   if (beat_S) state_SN = closing_S ? FINAL : ACCUM;
      FINAL:         state_SN = OUTPUT_STABLE;
      OUTPUT_STABLE: if (ReadyIn_SI) state_SN = IDLE;
      default:       state_SN = IDLE;
    endcase
  end

  always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
    if (!Reset_RBI) state_SP <= IDLE;
    else            state_SP <= state_SN;
  end

  // Accumulation stage: per-bit ones-counts, sample count, label and tie-break capture.
  always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
    if (!Reset_RBI) begin
      for (int j = 0; j < HV_DIMENSION; j++) bitCnt_DP[j] <= '0;
      sampleCnt_DP <= '0;
      tieBreak_DP  <= '0;
      label_DP     <= '0;
    end else if (beat_S) begin
      sampleCnt_DP <= sampleCntNext_D;
      for (int j = 0; j < HV_DIMENSION; j++) begin
        if (firstBeat_S) bitCnt_DP[j] <= CNT_WIDTH'(HypervectorIn_DI[j]);
        else             bitCnt_DP[j] <= bitCnt_DP[j] + CNT_WIDTH'(HypervectorIn_DI[j]);
      end
      if (firstBeat_S) begin
        tieBreak_DP <= HypervectorIn_DI;
        label_DP    <= LabelIn_DI;
      end
    end else if (state_SP == FINAL) begin
      for (int j = 0; j < HV_DIMENSION; j++) bitCnt_DP[j] <= '0;
      sampleCnt_DP <= '0;
    end
  end

  // Output stage: the prototype is captured once in FINAL and held until the next FINAL.
  always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
    if (!Reset_RBI) begin
      PrototypeOut_DO <= '0;
      LabelOut_DO     <= '0;
      CountOut_DO     <= '0;
    end else if (state_SP == FINAL) begin
      for (int j = 0; j < HV_DIMENSION; j++)
        PrototypeOut_DO[j] <= majorityBit(bitCnt_DP[j], sampleCnt_DP, tieBreak_DP[j]);
      LabelOut_DO <= label_DP;
      CountOut_DO <= sampleCnt_DP;
    end
  end

endmodule
